// File: rtl/button_input_pkg.sv
// ---------------------------------------------------------------------------
// button_input_pkg
//   Shared definitions for the push-button debounce block.
//   - btn_state_t : per-channel FSM state encoding
//   - max_int     : elaboration-time helper used to size the shared counters
// ---------------------------------------------------------------------------
package button_input_pkg;

  // Per-channel debounce/hold FSM state.
  //   ST_IDLE       : released and stable, level 0
  //   ST_DB_PRESS   : pressed samples being counted, level still 0
  //   ST_HELD       : press accepted, level 1, hold time accumulating
  //   ST_DB_RELEASE : released samples being counted, level still 1
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } btn_state_t;

  // Larger of two integers; used at elaboration time only.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_input_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//   One push-button channel: 2-flop synchronizer, polarity normalisation,
//   debounce FSM and hold timer.
//
// Ports
//   clk50        in  1  system clock
//   reset_n      in  1  synchronous active-low reset
//   pin          in  1  raw asynchronous button pin
//   level        out 1  debounced pressed level (1 = pressed), registered
//   press_strb   out 1  one-cycle strobe on accepted press, registered
//   release_strb out 1  one-cycle strobe on accepted release, registered
//   long_strb    out 1  one-cycle strobe when the hold time reaches
//                       LONG_PRESS_CYCLES, at most once per press
//   press_nxt    out 1  combinational value that press_strb loads on the
//                       next edge; lets the parent update its press counter
//                       on the same edge the strobe asserts
// ---------------------------------------------------------------------------
module debounce_channel
  import button_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter bit ACTIVE_LOW_IN     = 1'b1
) (
  input  logic clk50,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic press_strb,
  output logic release_strb,
  output logic long_strb,
  output logic press_nxt
);

  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // Pin level of a released button; the synchronizer resets to this so a
  // reset never manufactures a press edge on its own.
  localparam logic PIN_IDLE = ACTIVE_LOW_IN;

  logic             sync_p0;
  logic             sync_p1;
  logic             pressed;

  btn_state_t       state;
  btn_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] hold;
  logic [CNT_W-1:0] hold_nxt;
  logic             release_nxt;
  logic             long_nxt;
  logic             level_nxt;

  // ---- stage p0/p1: two-flop synchronizer ----
  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      sync_p0 <= PIN_IDLE;
      sync_p1 <= PIN_IDLE;
    end else begin
      sync_p0 <= pin;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: polarity normalise, FSM decode ----
  // XOR with the polarity flag inverts an active-low pin so pressed = 1.
  assign pressed = sync_p1 ^ ACTIVE_LOW_IN;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hold_nxt    = hold;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pressed) begin
          state_nxt = ST_DB_PRESS;
          cnt_nxt   = CNT_ONE;
        end
      end

      ST_DB_PRESS: begin
        if (!pressed) begin
          // Bounce: drop back without any strobe.
          state_nxt = ST_IDLE;
        end else if (cnt >= DEB_LAST) begin
          // Counter reached the threshold and the pin is still pressed.
          state_nxt = ST_HELD;
          press_nxt = 1'b1;
          hold_nxt  = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      ST_HELD: begin
        if (!pressed) begin
          state_nxt = ST_DB_RELEASE;
          cnt_nxt   = CNT_ONE;
        end else if (hold < LONG_LAST) begin
          // Saturating hold timer; the long strobe fires only on the step
          // into LONG_LAST, so a saturated timer never repeats it.
          hold_nxt = hold + CNT_ONE;
          long_nxt = (hold == (LONG_LAST - CNT_ONE));
        end
      end

      ST_DB_RELEASE: begin
        if (pressed) begin
          // Release bounce: resume the hold without re-announcing it.
          state_nxt = ST_HELD;
        end else if (cnt >= DEB_LAST) begin
          state_nxt   = ST_IDLE;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Level follows the state being entered so it drops on the same edge
    // as the release strobe and rises with the press strobe.
    level_nxt = (state_nxt == ST_HELD) || (state_nxt == ST_DB_RELEASE);
  end

  // ---- stage p3: registered state, counters and outputs ----
  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      hold         <= '0;
      level        <= 1'b0;
      press_strb   <= 1'b0;
      release_strb <= 1'b0;
      long_strb    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      hold         <= hold_nxt;
      level        <= level_nxt;
      press_strb   <= press_nxt;
      release_strb <= release_nxt;
      long_strb    <= long_nxt;
    end
  end

endmodule

// File: rtl/button_input.sv
// ---------------------------------------------------------------------------
// button_input
//   Samples raw board push-buttons on clk50, debounces each one and reports
//   clean levels, one-cycle press/release/long-press strobes and a running
//   6-bit count of accepted presses across all channels.
//
// Ports
//   clk50        in  1            system clock (50 MHz)
//   reset_n      in  1            synchronous active-low reset
//   buttons_in   in  NUM_BUTTONS  raw asynchronous button pins
//   btn_level    out NUM_BUTTONS  debounced pressed level, 1 = pressed
//   btn_press    out NUM_BUTTONS  one-cycle strobe on accepted press
//   btn_release  out NUM_BUTTONS  one-cycle strobe on accepted release
//   btn_long     out NUM_BUTTONS  one-cycle strobe at the long-press threshold
//   press_count  out 6            accepted presses, all channels, modulo 64
// ---------------------------------------------------------------------------
module button_input
  import button_input_pkg::*;
#(
  parameter int NUM_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter bit ACTIVE_LOW_IN     = 1'b1
) (
  input  logic                   clk50,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] buttons_in,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic [NUM_BUTTONS-1:0] btn_long,
  output logic [5:0]             press_count
);

  logic [NUM_BUTTONS-1:0] press_nxt;

  // Number of set bits, wrapping at 64 like the counter it feeds.
  function automatic logic [5:0] popcount(input logic [NUM_BUTTONS-1:0] v);
    logic [5:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      sum = sum + 6'(v[i]);
    end
    return sum;
  endfunction

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
      .ACTIVE_LOW_IN     (ACTIVE_LOW_IN)
    ) u_chan (
      .clk50        (clk50),
      .reset_n      (reset_n),
      .pin          (buttons_in[i]),
      .level        (btn_level[i]),
      .press_strb   (btn_press[i]),
      .release_strb (btn_release[i]),
      .long_strb    (btn_long[i]),
      .press_nxt    (press_nxt[i])
    );
  end

  // ---- press counter: advances on the edge that raises btn_press ----
  // Built from the channels' next-cycle press decode so the count and the
  // strobes it accounts for become visible together.
  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      press_count <= '0;
    end else begin
      press_count <= press_count + popcount(press_nxt);
    end
  end

endmodule
